// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_ctrl_pkg;

  // Width of the saturating stall/flush statistics counters.
  localparam int unsigned CntWidth = 16;

  // Controller FSM states; HALT and FAULT are terminal until reset.
  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StHalt    = 2'd2,
    StFault   = 2'd3
  } state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side hazard inputs and stage-control outputs of hazard_ctrl.
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  logic [2:0]          id_rs;
  logic [2:0]          id_rt;
  logic                id_rs_used;
  logic                id_rt_used;
  logic [2:0]          ex_writereg;
  logic                ex_memread;
  logic                ex_regwrite;
  logic                ex_redirect;
  logic                mem_busy;
  logic                wb_halt;
  logic                pc_en;
  logic                ifid_en;
  logic                idex_en;
  logic                exmem_en;
  logic                memwb_en;
  logic                ifid_nopify;
  logic                idex_nopify;
  logic                halted;
  logic                fault;
  logic [CntWidth-1:0] stall_count;
  logic [CntWidth-1:0] flush_count;

  // Pipeline datapath side: presents hazard information, consumes controls.
  modport master (
    output id_rs, id_rt, id_rs_used, id_rt_used, ex_writereg, ex_memread, ex_regwrite,
           ex_redirect, mem_busy, wb_halt,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_nopify, idex_nopify,
           halted, fault, stall_count, flush_count
  );

  // Controller side.
  modport slave (
    input  id_rs, id_rt, id_rs_used, id_rt_used, ex_writereg, ex_memread, ex_regwrite,
           ex_redirect, mem_busy, wb_halt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_nopify, idex_nopify,
           halted, fault, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_ctrl_sat_counter16.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_counter16
  import hazard_ctrl_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                inc_i,
  output logic [CntWidth-1:0] count_o
);

  logic [CntWidth-1:0] count_d, count_q;

  // Next count: increment unless already at all-ones.
  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {CntWidth{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline sequencing controller: load-use stalls, redirect flushes,
// data-memory wait with timeout watchdog, halt retirement and statistics.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave bus
);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);

  state_e             state_d, state_q;
  logic [WaitW-1:0]   wait_cnt_d, wait_cnt_q;
  logic [WaitW-1:0]   wait_next;
  logic               load_use;
  logic               stall_inc, flush_inc;
  logic               pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic               ifid_nop, idex_nop;
  logic [CntWidth-1:0] stall_count, flush_count;

  // Register 0 is an ordinary register here, so no zero-register exemption.
  always_comb begin
    load_use = bus.ex_memread && bus.ex_regwrite &&
               ((bus.id_rs_used && (bus.id_rs == bus.ex_writereg)) ||
                (bus.id_rt_used && (bus.id_rt == bus.ex_writereg)));
  end

  // Next state, wait counter, stage controls and statistic increments.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    wait_next  = '0;
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    idex_en    = 1'b0;
    exmem_en   = 1'b0;
    memwb_en   = 1'b0;
    ifid_nop   = 1'b0;
    idex_nop   = 1'b0;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    unique case (state_q)
      StRun, StMemWait: begin
        if (bus.mem_busy) begin
          // wait_next is the number of consecutive busy cycles including this one.
          wait_next = ((state_q == StMemWait) ? wait_cnt_q : '0) + WaitW'(1);
          wait_cnt_d = wait_next;
          stall_inc  = 1'b1;
          state_d    = (wait_next == WaitW'(MEM_TIMEOUT)) ? StFault : StMemWait;
        end else begin
          wait_cnt_d = '0;
          state_d    = StRun;
          if (bus.wb_halt) begin
            stall_inc = 1'b1;
            state_d   = StHalt;
          end else if (bus.ex_redirect) begin
            // Decode instruction is squashed, so any load-use match is moot.
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
            ifid_nop  = 1'b1;
            idex_nop  = 1'b1;
            flush_inc = 1'b1;
          end else if (load_use) begin
            {idex_en, exmem_en, memwb_en} = 3'b111;
            idex_nop  = 1'b1;
            stall_inc = 1'b1;
          end else begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
          end
        end
      end
      StHalt, StFault: begin
        state_d = state_q;
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  // State and wait counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StRun;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  sat_counter16 u_stall_cnt (
    .clk_i   (clk),
    .rst_ni  (rst),
    .inc_i   (stall_inc),
    .count_o (stall_count)
  );

  sat_counter16 u_flush_cnt (
    .clk_i   (clk),
    .rst_ni  (rst),
    .inc_i   (flush_inc),
    .count_o (flush_count)
  );

  // Drive outputs; controls are held inactive while reset is asserted.
  always_comb begin
    bus.pc_en       = rst & pc_en;
    bus.ifid_en     = rst & ifid_en;
    bus.idex_en     = rst & idex_en;
    bus.exmem_en    = rst & exmem_en;
    bus.memwb_en    = rst & memwb_en;
    bus.ifid_nopify = rst & ifid_nop;
    bus.idex_nopify = rst & idex_nop;
    bus.halted      = (state_q == StHalt);
    bus.fault       = (state_q == StFault);
    bus.stall_count = stall_count;
    bus.flush_count = flush_count;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: two instances (timeout 255 and 3) against a
// behavioural model, plus hand-computed literal checks.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] id_rs, id_rt, ex_wr;
  logic       rs_used, rt_used, memread, regwrite, redirect, busy, halt;

  int vectors = 0;
  int miscompares = 0;

  hazard_ctrl_if a_if ();
  hazard_ctrl_if b_if ();

  hazard_ctrl #(.MEM_TIMEOUT(255)) u_a (.clk(clk), .rst(rst), .bus(a_if.slave));
  hazard_ctrl #(.MEM_TIMEOUT(3))   u_b (.clk(clk), .rst(rst), .bus(b_if.slave));

  always_comb begin
    a_if.id_rs = id_rs;        b_if.id_rs = id_rs;
    a_if.id_rt = id_rt;        b_if.id_rt = id_rt;
    a_if.id_rs_used = rs_used; b_if.id_rs_used = rs_used;
    a_if.id_rt_used = rt_used; b_if.id_rt_used = rt_used;
    a_if.ex_writereg = ex_wr;  b_if.ex_writereg = ex_wr;
    a_if.ex_memread = memread; b_if.ex_memread = memread;
    a_if.ex_regwrite = regwrite; b_if.ex_regwrite = regwrite;
    a_if.ex_redirect = redirect; b_if.ex_redirect = redirect;
    a_if.mem_busy = busy;      b_if.mem_busy = busy;
    a_if.wb_halt = halt;       b_if.wb_halt = halt;
  end

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  // mode: 0 = running (possibly waiting on memory), 1 = halted, 2 = faulted
  int          m_mode[2];
  int          m_busy[2];   // consecutive busy cycles seen so far
  int          m_stall[2];
  int          m_flush[2];
  int unsigned tmo[2] = '{255, 3};

  function automatic bit lu_now();
    return memread && regwrite &&
           ((rs_used && id_rs == ex_wr) || (rt_used && id_rt == ex_wr));
  endfunction

  // Expected {pc, ifid, idex, exmem, memwb, ifid_nop, idex_nop}.
  function automatic logic [6:0] exp_ctl(int i);
    if (!rst || m_mode[i] != 0 || busy || halt) return 7'b00000_00;
    if (redirect) return 7'b11111_11;
    if (lu_now()) return 7'b00111_01;
    return 7'b11111_00;
  endfunction

  function automatic int sat(int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      for (int i = 0; i < 2; i++) begin
        if (!rst) begin
          m_mode[i] = 0; m_busy[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
        end else if (m_mode[i] == 0) begin
          if (busy) begin
            m_busy[i]++;
            m_stall[i] = sat(m_stall[i] + 1);
            if (m_busy[i] >= int'(tmo[i])) m_mode[i] = 2;
          end else begin
            m_busy[i] = 0;
            if (halt) begin
              m_mode[i] = 1;
              m_stall[i] = sat(m_stall[i] + 1);
            end else if (redirect) begin
              m_flush[i] = sat(m_flush[i] + 1);
            end else if (lu_now()) begin
              m_stall[i] = sat(m_stall[i] + 1);
            end
          end
        end
      end
    end
  end

  function automatic logic [40:0] exp_vec(int i);
    return {exp_ctl(i), m_mode[i] == 1, m_mode[i] == 2,
            16'(m_stall[i]), 16'(m_flush[i])};
  endfunction

  // Compare both instances against the model on every falling edge.
  always @(negedge clk) begin
    check("model_a", {a_if.pc_en, a_if.ifid_en, a_if.idex_en, a_if.exmem_en, a_if.memwb_en,
                      a_if.ifid_nopify, a_if.idex_nopify, a_if.halted, a_if.fault,
                      a_if.stall_count, a_if.flush_count}, exp_vec(0));
    check("model_b", {b_if.pc_en, b_if.ifid_en, b_if.idex_en, b_if.exmem_en, b_if.memwb_en,
                      b_if.ifid_nopify, b_if.idex_nopify, b_if.halted, b_if.fault,
                      b_if.stall_count, b_if.flush_count}, exp_vec(1));
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    id_rs = 3'd0; id_rt = 3'd0; ex_wr = 3'd7;
    rs_used = 0; rt_used = 0; memread = 0; regwrite = 0;
    redirect = 0; busy = 0; halt = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b0;
    idle();
    @(negedge clk);
    tick();
    rst = 1'b1;
  endtask

  task automatic set_lu_r3();
    memread = 1; regwrite = 1; ex_wr = 3'd3; id_rs = 3'd3; id_rt = 3'd5;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no_finish expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    idle();
    @(negedge clk);
    check("rst_pc_en", a_if.pc_en, 0);
    check("rst_stall", a_if.stall_count, 0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("run_pc_en", a_if.pc_en, 1);

    // Load-use on rs: exactly one bubble cycle.
    tick(); set_lu_r3(); rs_used = 1;
    @(negedge clk);
    check("lu_ctl", {a_if.pc_en, a_if.ifid_en, a_if.idex_en, a_if.idex_nopify}, 4'b0011);
    tick(); idle();
    @(negedge clk);
    check("lu_release", a_if.pc_en, 1);
    check("lu_stall1", a_if.stall_count, 1);

    // Same registers, no source actually used: no bubble.
    tick(); set_lu_r3(); id_rt = 3'd3;
    @(negedge clk);
    check("nouse_ctl", {a_if.pc_en, a_if.ifid_en, a_if.idex_nopify}, 3'b110);
    // Register 0 via rt is matched.
    tick(); memread = 1; regwrite = 1; ex_wr = 3'd0; id_rt = 3'd0; rt_used = 1;
    id_rs = 3'd4; rs_used = 1;
    @(negedge clk);
    check("r0_pc_en", a_if.pc_en, 0);
    tick(); idle();
    @(negedge clk);
    check("r0_stall2", a_if.stall_count, 2);

    // Redirect wins over a simultaneous load-use.
    do_reset();
    tick(); set_lu_r3(); rs_used = 1; redirect = 1;
    @(negedge clk);
    check("redir_ctl", {a_if.pc_en, a_if.ifid_en, a_if.ifid_nopify, a_if.idex_nopify},
          4'b1111);
    tick(); idle();
    @(negedge clk);
    check("redir_flush", a_if.flush_count, 1);
    check("redir_stall", a_if.stall_count, 0);

    // Four busy cycles on the long-timeout instance.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      tick(); busy = 1;
      @(negedge clk);
      check("busy_en", {a_if.pc_en, a_if.ifid_en, a_if.idex_en, a_if.exmem_en, a_if.memwb_en},
            5'b00000);
    end
    tick(); idle();
    @(negedge clk);
    check("busy_stall4", a_if.stall_count, 4);
    check("busy_nofault", a_if.fault, 0);
    check("busy_resume", a_if.pc_en, 1);
    check("busy_b_fault", b_if.fault, 1);

    // Busy drops in the third cycle: short-timeout instance stays out of FAULT.
    do_reset();
    tick(); busy = 1;
    tick(); busy = 1;
    tick(); busy = 0;
    @(negedge clk);
    check("edge_b_pc_en", b_if.pc_en, 1);
    tick(); idle();
    @(negedge clk);
    check("edge_b_nofault", b_if.fault, 0);

    // Held busy: FAULT after the third edge, sticky until reset.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      tick(); busy = 1;
    end
    tick(); idle();
    @(negedge clk);
    check("tmo_fault", b_if.fault, 1);
    check("tmo_pc_en", b_if.pc_en, 0);
    tick();
    @(negedge clk);
    check("tmo_sticky", {b_if.fault, b_if.memwb_en}, 2'b10);
    tick(); rst = 1'b0;
    @(negedge clk);
    check("tmo_rst_fault", b_if.fault, 0);
    tick(); rst = 1'b1;
    @(negedge clk);
    check("tmo_rst_run", b_if.pc_en, 1);

    // Halt held behind two busy cycles, accepted in the third.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      tick(); busy = 1; halt = 1;
      @(negedge clk);
      check("halt_wait", {a_if.halted, a_if.pc_en}, 2'b00);
    end
    tick(); busy = 0; halt = 1;
    @(negedge clk);
    check("halt_accept", {a_if.halted, a_if.pc_en, a_if.memwb_en}, 3'b000);
    tick(); idle(); redirect = 1;
    @(negedge clk);
    check("halted", a_if.halted, 1);
    check("halt_en", {a_if.pc_en, a_if.ifid_en, a_if.idex_en, a_if.exmem_en, a_if.memwb_en},
          5'b00000);
    check("halt_stall3", a_if.stall_count, 3);
    check("halt_noflush", a_if.flush_count, 0);
    tick(); rst = 1'b0; idle();
    @(negedge clk);
    check("halt_rst", {a_if.halted, a_if.stall_count}, 17'd0);
    tick(); rst = 1'b1;
    tick();
    @(negedge clk);
    check("halt_rst_run", a_if.pc_en, 1);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
